// File: rtl/cpu_sram_arbiter_pkg.sv
// rtl/cpu_sram_arbiter_pkg.sv - shared encodings and defaults for the fetch/mem SRAM port arbiter
//
// Purpose: state and owner encodings shared by the arbiter top and its grant
// sub-module, plus the default anti-starvation run length.
package cpu_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arbOwner_t;

    // Consecutive data grants tolerated while a fetch is waiting (1..15).
    localparam int DEFAULT_MAX_DATA_RUN = 4;
    localparam int RUN_CNT_W            = 4;

endpackage

// File: rtl/sram_arb_grant.sv
// rtl/sram_arb_grant.sv - data-priority grant logic with anti-starvation run counter
//
// Purpose: decides which requester wins the memory port in an idle cycle.
// Data wins unless a fetch has already watched MAX_DATA_RUN data grants go by.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   arbIdle              arbiter may grant this cycle
//   instReq, dataReq     request levels from fetch and mem stages
//   grantInst, grantData one-hot grant for this cycle (combinational)
module sram_arb_grant
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int MAX_DATA_RUN = DEFAULT_MAX_DATA_RUN
) (
    input  logic clk,
    input  logic rst,
    input  logic arbIdle,
    input  logic instReq,
    input  logic dataReq,
    output logic grantInst,
    output logic grantData
);

    localparam logic [RUN_CNT_W-1:0] MAX_RUN = RUN_CNT_W'(MAX_DATA_RUN);

    logic [RUN_CNT_W-1:0] runCnt;
    logic                 runAtMax;

    assign runAtMax = (runCnt == MAX_RUN);

    always_comb begin
        grantData = arbIdle && dataReq && !(instReq && runAtMax);
        grantInst = arbIdle && instReq && !grantData;
    end

    // Counts only data grants that a waiting fetch had to sit through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            runCnt <= '0;
        end else if (grantInst) begin
            runCnt <= '0;
        end else if (grantData) begin
            if (!instReq)
                runCnt <= '0;
            else if (!runAtMax)
                runCnt <= runCnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// rtl/cpu_sram_arbiter.sv - single-outstanding arbiter sharing one SRAM-like port between fetch and mem
//
// Purpose: grants fetch or data access to the downstream bus, holds the
// granted request stable until the bus takes it, and returns the read word
// to the owning side as a one-cycle data_ok pulse.
// Ports:
//   clk, rst                                   clock, asynchronous active-high reset
//   inst_req/inst_addr -> inst_addr_ok         fetch request handshake
//   inst_data_ok/inst_rdata                    fetch completion pulse and word
//   data_req/wr/wstrb/addr/wdata -> addr_ok    mem-stage request handshake
//   data_data_ok/data_rdata                    mem completion pulse and load word
//   bus_req/wr/wstrb/addr/wdata                downstream request (registered fields)
//   bus_addr_ok/bus_data_ok/bus_rdata          downstream handshake and read data
//   busy_stall                                 a side is waiting on the arbiter
module cpu_sram_arbiter
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int MAX_DATA_RUN = DEFAULT_MAX_DATA_RUN,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata,
    output logic              busy_stall
);

    arbState_t         state;
    arbState_t         nextState;
    arbOwner_t         ownerQ;
    logic              wrQ;
    logic [3:0]        wstrbQ;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wdataQ;
    logic              arbIdle;
    logic              grantInst;
    logic              grantData;
    logic              busDone;

    // Gated by rst so the combinational handshakes are also 0 while in reset.
    assign arbIdle = (state == ST_IDLE) && !rst;

    sram_arb_grant #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .arbIdle  (arbIdle),
        .instReq  (inst_req),
        .dataReq  (data_req),
        .grantInst(grantInst),
        .grantData(grantData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        busDone   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grantInst || grantData)
                    nextState = ST_REQ;
            end
            ST_REQ: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        nextState = ST_IDLE;
                        busDone   = 1'b1;
                    end else begin
                        nextState = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    nextState = ST_IDLE;
                    busDone   = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Requesters may move on after addr_ok; the bus only ever sees these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ownerQ <= OWN_INST;
            wrQ    <= 1'b0;
            wstrbQ <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
        end else if (grantData) begin
            ownerQ <= OWN_DATA;
            wrQ    <= data_wr;
            wstrbQ <= data_wstrb;
            addrQ  <= data_addr;
            wdataQ <= data_wdata;
        end else if (grantInst) begin
            ownerQ <= OWN_INST;
            wrQ    <= 1'b0;
            wstrbQ <= '0;
            addrQ  <= inst_addr;
            wdataQ <= '0;
        end
    end

    // rdata is captured on stores too and then held until that side completes again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
        end else begin
            inst_data_ok <= busDone && (ownerQ == OWN_INST);
            data_data_ok <= busDone && (ownerQ == OWN_DATA);
            if (busDone && ownerQ == OWN_INST)
                inst_rdata <= bus_rdata;
            if (busDone && ownerQ == OWN_DATA)
                data_rdata <= bus_rdata;
        end
    end

    assign inst_addr_ok = grantInst;
    assign data_addr_ok = grantData;

    assign bus_req   = (state == ST_REQ);
    assign bus_wr    = wrQ;
    assign bus_wstrb = wstrbQ;
    assign bus_addr  = addrQ;
    assign bus_wdata = wdataQ;

    assign busy_stall = !rst && ((state != ST_IDLE)
                                 || (data_req && !grantData)
                                 || (inst_req && !grantInst));

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// tb/tb_cpu_sram_arbiter.sv - scoreboard bench for cpu_sram_arbiter
module tb_cpu_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy_stall;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected completions in order, and read words the bus will return.
    bit          expSideQ[$];
    logic [31:0] expDataQ[$];
    logic [31:0] busRdataQ[$];

    int addrDelay = 0;
    int dataDelay = 0;

    always #5 clk = ~clk;

    cpu_sram_arbiter #(
        .MAX_DATA_RUN(4),
        .ADDR_W      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .busy_stall  (busy_stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] popRdata();
        if (busRdataQ.size() == 0)
            return 32'h0;
        return busRdataQ.pop_front();
    endfunction

    // Bus model: addr_ok after addrDelay cycles of bus_req, data_ok dataDelay cycles later.
    initial begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (bus_req === 1'b1) begin
                repeat (addrDelay) @(negedge clk);
                bus_addr_ok = 1'b1;
                if (dataDelay == 0) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = popRdata();
                end
                @(negedge clk);
                bus_addr_ok = 1'b0;
                bus_data_ok = 1'b0;
                if (dataDelay > 0) begin
                    repeat (dataDelay - 1) @(negedge clk);
                    bus_data_ok = 1'b1;
                    bus_rdata   = popRdata();
                    @(negedge clk);
                    bus_data_ok = 1'b0;
                end
            end
        end
    end

    // Monitor: every data_ok pulse must match the head of the scoreboard.
    initial begin
        bit          side;
        logic [31:0] word;
        forever begin
            @(negedge clk);
            if (inst_data_ok || data_data_ok) begin
                if (expSideQ.size() == 0) begin
                    check("resp_unexpected", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
                end else begin
                    side = expSideQ.pop_front();
                    word = expDataQ.pop_front();
                    check("resp_side", {30'b0, inst_data_ok, data_data_ok}, side ? 32'h1 : 32'h2);
                    check("resp_rdata", side ? data_rdata : inst_rdata, word);
                end
            end
        end
    end

    task automatic expectResp(input bit isData, input logic [31:0] word);
        busRdataQ.push_back(word);
        expSideQ.push_back(isData);
        expDataQ.push_back(word);
    endtask

    task automatic issue(input bit isData, input logic [31:0] addr, input logic [31:0] word,
                         input bit wantResp);
        bit got = 1'b0;
        if (wantResp)
            expectResp(isData, word);
        else
            busRdataQ.push_back(word);
        @(posedge clk); #1;
        if (isData) begin
            data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = addr;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (isData ? data_addr_ok : inst_addr_ok) begin
                got = 1'b1;
                break;
            end
        end
        check("issue_granted", {31'b0, got}, 32'h1);
        @(posedge clk); #1;
        inst_req = 1'b0;
        data_req = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_stall && !bus_req && expSideQ.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, {31'b0, done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] order;
        int         n;
        int         pulses;

        rst = 1'b1;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;

        // Reset state, including a request raised while reset is held.
        repeat (2) @(negedge clk);
        inst_req = 1'b1;
        #1;
        check("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
        check("rst_busy_stall", {31'b0, busy_stall}, 32'h0);
        check("rst_bus_req", {31'b0, bus_req}, 32'h0);
        check("rst_rdata", inst_rdata | data_rdata | bus_addr, 32'h0);
        inst_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single fetch: addr_ok at 1, data_ok at 3 -> inst_data_ok at 4.
        addrDelay = 0; dataDelay = 2;
        expectResp(1'b0, 32'h24080001);
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        @(negedge clk);
        check("f_addr_ok_c0", {31'b0, inst_addr_ok}, 32'h1);
        check("f_bus_req_c0", {31'b0, bus_req}, 32'h0);
        @(posedge clk); #1;
        inst_req = 1'b0; inst_addr = 32'h0;
        @(negedge clk);
        check("f_bus_req_c1", {31'b0, bus_req}, 32'h1);
        check("f_bus_addr_c1", bus_addr, 32'hBFC00000);
        check("f_bus_wr_c1", {27'b0, bus_wr, bus_wstrb}, 32'h0);
        @(negedge clk);
        check("f_bus_req_c2", {31'b0, bus_req}, 32'h0);
        check("f_busy_c2", {31'b0, busy_stall}, 32'h1);
        @(negedge clk);
        check("f_data_ok_c3", {31'b0, inst_data_ok}, 32'h0);
        @(negedge clk);
        check("f_data_ok_c4", {31'b0, inst_data_ok}, 32'h1);
        @(negedge clk);
        check("f_data_ok_c5", {31'b0, inst_data_ok}, 32'h0);
        check("f_rdata_held", inst_rdata, 32'h24080001);
        check("f_busy_c5", {31'b0, busy_stall}, 32'h0);

        // Store with same-cycle bus completion.
        addrDelay = 0; dataDelay = 0;
        expectResp(1'b1, 32'hA5A5A5A5);
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("s_addr_ok_c0", {31'b0, data_addr_ok}, 32'h1);
        @(posedge clk); #1;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        @(negedge clk);
        check("s_bus_req_c1", {31'b0, bus_req}, 32'h1);
        check("s_bus_wr_strb", {27'b0, bus_wr, bus_wstrb}, 32'h13);
        check("s_bus_addr", bus_addr, 32'h80000010);
        check("s_bus_wdata", bus_wdata, 32'hDEADBEEF);
        @(negedge clk);
        check("s_data_ok_c2", {31'b0, data_data_ok}, 32'h1);
        check("s_busy_c2", {31'b0, busy_stall}, 32'h0);
        waitIdle("s_idle");

        // Contention: both sides held high, expect D,D,D,D,I,D,D,D,D,I.
        order = '0;
        n = 0;
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'hBFC00100;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000100;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (inst_addr_ok && data_addr_ok)
                check("c_both_granted", {30'b0, inst_addr_ok, data_addr_ok}, 32'h0);
            if (inst_addr_ok || data_addr_ok) begin
                order[n] = data_addr_ok;
                expectResp(data_addr_ok, 32'h10000000 + n);
                n++;
            end
        end
        @(posedge clk); #1;
        inst_req = 1'b0; data_req = 1'b0;
        check("c_grant_count", n, 32'd10);
        check("c_grant_order", {22'b0, order}, 32'h1EF);
        waitIdle("c_idle");

        // Slow bus: addr_ok withheld 6 cycles while upstream fields keep changing.
        addrDelay = 6; dataDelay = 1;
        expectResp(1'b1, 32'h12345678);
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h80000020; data_wdata = 32'h11112222;
        @(negedge clk);
        check("w_addr_ok_c0", {31'b0, data_addr_ok}, 32'h1);
        @(posedge clk); #1;
        data_addr = 32'h80000024; data_wdata = 32'h0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("w_bus_req", {31'b0, bus_req}, 32'h1);
            check("w_bus_addr", bus_addr, 32'h80000020);
            check("w_bus_wdata", bus_wdata, 32'h11112222);
            check("w_busy", {31'b0, busy_stall}, 32'h1);
            check("w_no_second_ok", {31'b0, data_addr_ok}, 32'h0);
            @(posedge clk); #1;
            if (i == 6)
                data_req = 1'b0;
            else
                data_addr = data_addr + 32'd4;
        end
        waitIdle("w_idle");

        // Stale data: a fetch completing must not touch data_rdata.
        addrDelay = 0; dataDelay = 0;
        issue(1'b0, 32'hBFC00004, 32'hCAFEF00D, 1'b1);
        waitIdle("st_idle");
        check("st_data_rdata", data_rdata, 32'h12345678);
        check("st_inst_rdata", inst_rdata, 32'hCAFEF00D);

        // Async reset while in WAIT; the late bus_data_ok must be ignored.
        addrDelay = 0; dataDelay = 5;
        issue(1'b0, 32'hBFC00200, 32'hBAD0BAD0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        inst_req = 1'b1;
        #1;
        check("r_outputs_zero", inst_rdata | data_rdata | bus_addr | bus_wdata, 32'h0);
        check("r_flags_zero", {24'b0, bus_req, bus_wr, busy_stall, inst_addr_ok,
                               data_addr_ok, inst_data_ok, data_data_ok, 1'b0}, 32'h0);
        inst_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pulses += int'(inst_data_ok) + int'(data_data_ok);
        end
        check("r_late_data_ok_ignored", pulses, 32'd0);
        addrDelay = 0; dataDelay = 0;
        issue(1'b0, 32'hBFC00300, 32'h0BADF00D, 1'b1);
        waitIdle("r_idle");
        check("r_after_rdata", inst_rdata, 32'h0BADF00D);

        check("sb_empty", expSideQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sram_arbiter.md
Name: cpu_sram_arbiter

Overview:
- Shares the single SRAM-like memory port between the fetch stage (instruction reads) and the mem stage (data loads/stores, byte strobes from write_data).
- One outstanding transaction at a time. Data side has priority, bounded by an anti-starvation counter.
- Sits between the pipeline and the bus bridge.
- Exports `busy_stall` to the hazard unit so stallF/stallD/stallE can be asserted while a side waits.

Parameters:
- MAX_DATA_RUN, 4, consecutive data grants allowed while inst_req is pending before inst is forced (range 1..15).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- inst_req  in  1  fetch request (level, held until inst_addr_ok)
- inst_addr  in  ADDR_W  fetch address (pcF)
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  32  fetched word (instrF)
- data_req  in  1  data request (level, held until data_addr_ok)
- data_wr  in  1  1=store, 0=load
- data_wstrb  in  4  byte enables (sig_write)
- data_addr  in  ADDR_W  aluoutM
- data_wdata  in  32  writedataM
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  one-cycle pulse: load data valid / store done
- data_rdata  out  32  load word (readdataM)
- bus_req  out  1  downstream request
- bus_wr  out  1  downstream write
- bus_wstrb  out  4  downstream strobes
- bus_addr  out  ADDR_W  downstream address
- bus_wdata  out  32  downstream write data
- bus_addr_ok  in  1  downstream accepted address
- bus_data_ok  in  1  downstream completed
- bus_rdata  in  32  downstream read data
- busy_stall  out  1  1 while any accepted request has not yet returned data_ok

Behaviour:
- Reset (async, any state): state=IDLE, owner=INST, run_cnt=0.
  - All outputs 0, including inst_rdata and data_rdata.
  - An outstanding bus transaction is abandoned. A bus_data_ok arriving while IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE, grant rule:
  - Data wins if data_req && !(inst_req && run_cnt==MAX_DATA_RUN).
  - Otherwise inst wins if inst_req.
  - On grant: assert <side>_addr_ok combinationally in the same cycle, and register owner, wr, wstrb, addr, wdata. Go to REQ.
  - Inst grants force wr=0 and wstrb=0.
- run_cnt:
  - Increments on a data grant while inst_req=1, saturating at MAX_DATA_RUN.
  - Clears on any inst grant, or on a data grant with inst_req=0.
- REQ:
  - bus_req=1; bus_* driven from the registered fields, stable until bus_addr_ok.
  - bus_addr_ok && !bus_data_ok -> WAIT.
  - bus_addr_ok && bus_data_ok in the same cycle -> completes directly to IDLE.
- WAIT:
  - bus_req=0.
  - bus_data_ok -> IDLE.
- Completion (cycle with bus_data_ok in WAIT or REQ):
  - Next cycle: owner's data_ok=1 for exactly one cycle.
  - owner's rdata <= bus_rdata, captured for stores too.
  - rdata holds until that side's next completion.
- No new grant in the completion cycle. The earliest re-grant is the cycle data_ok pulses (state IDLE).
- Minimum latency: req at cycle 0 -> bus_req at 1 -> (addr_ok+data_ok at 1) -> <side>_data_ok at 2.
- busy_stall:
  - = (state!=IDLE) || (data_req && !data_addr_ok) || (inst_req && !inst_addr_ok).
  - Cleared in the data_ok pulse cycle unless a new request is pending and not granted.
- Requester fields may change freely after addr_ok; the arbiter uses only its registered copies.
- Simultaneous inst_req and data_req in IDLE:
  - run_cnt<MAX_DATA_RUN -> data granted, inst_addr_ok=0.
  - run_cnt==MAX_DATA_RUN -> inst granted.

Decomposition:
- Shared header cpu_bus_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_REQ=2'd1, ST_WAIT=2'd2
  - owner encodings OWN_INST=1'b0, OWN_DATA=1'b1
  - the default for MAX_DATA_RUN
- One natural sub-module: sram_arb_grant. It is the combinational priority plus the run_cnt register, with outputs grant_inst and grant_data.
- FSM, field registers and rdata capture stay in the top level.

Test Plan:
- Single fetch: inst_req=1, addr=0xBFC00000; bus_addr_ok at cycle 1, bus_data_ok at cycle 3 with rdata=0x24080001 -> inst_addr_ok at 0, bus_req at 1–1, inst_data_ok at 4 only, inst_rdata=0x24080001 held afterwards.
- Store: data_req=1, wr=1, wstrb=4'b0011, addr=0x80000010, wdata=0xDEADBEEF, bus answers addr_ok+data_ok same cycle -> bus_wr=1, bus_wstrb=0011, bus_wdata=0xDEADBEEF, data_data_ok at cycle 2, busy_stall low at cycle 2.
- Contention: inst_req and data_req both held high continuously, bus single-cycle, MAX_DATA_RUN=4 -> grant order D,D,D,D,I,D,D,D,D,I; inst never waits more than 5 grants.
- Slow bus: bus_addr_ok withheld 6 cycles with bus_addr changing upstream -> bus_addr/bus_wdata stay at the captured values; busy_stall=1 throughout; no second addr_ok.
- Async reset in WAIT: rst asserted mid-cycle -> all outputs 0 immediately. A late bus_data_ok after release produces no data_ok. The next inst_req is granted normally.
- Stale data: a load returns 0x12345678, then an inst transaction completes -> data_rdata still 0x12345678, inst_data_ok pulses, data_data_ok stays 0.
